// File: rtl/pkg_mst.sv
// Request bus driven by a bus master toward a slave.
package pkg_mst;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        cmd;   // 1 = write, 0 = read
    logic        req;
  } t_mst;

endpackage

// File: rtl/pkg_slv.sv
// Response bus driven by a slave back toward the bus master.
package pkg_slv;

  typedef struct packed {
    logic        ack;
    logic [31:0] data;
  } t_slv;

endpackage

// File: rtl/pkg_slv_st.sv
// State encoding and command constants for the register-file slave.
package pkg_slv_st;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAPT = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    REL  = 3'd4
  } t_slv_st;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

endpackage

// File: rtl/bus_slave_regfile.sv
// Register-file slave on the pkg_mst/pkg_slv four-phase request/ack bus.
//
// Handshake: the master raises req with addr/data/cmd valid; the slave
// captures those fields on the first edge it sees req high and ignores
// them afterwards. ack is a registered one-cycle pulse, rising after edge
// k+2+WAIT_CYCLES when req was first sampled at edge k. The master must
// then drop req; the slave returns to IDLE on the first edge that sees req
// low, so a req left high after a finished transfer is never re-accepted.
// Dropping req before the response aborts the transfer with no access and
// no ack. out_slv.data holds the last response until the next one.
module bus_slave_regfile
  import pkg_mst::*;
  import pkg_slv::*;
  import pkg_slv_st::*;
#(
  parameter int          DEPTH       = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] OOR_DATA    = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  t_mst       in_mst,
  output t_slv       out_slv,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  t_slv_st     state;
  t_slv_st     state_nxt;
  logic [31:0] mem [DEPTH];
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        cmd_q;
  logic [3:0]  wait_cnt;
  logic [IDX_W-1:0] idx;
  logic        in_range;

  // Index uses the low address bits; range check uses the whole address.
  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = (addr_q < 32'(DEPTH));
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a falling req before RESP abandons the transfer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_mst.req) state_nxt = CAPT;
      CAPT: begin
        if (!in_mst.req)          state_nxt = IDLE;
        else if (WAIT_CYCLES > 0) state_nxt = WAIT;
        else                      state_nxt = RESP;
      end
      WAIT: begin
        if (!in_mst.req)          state_nxt = IDLE;
        else if (wait_cnt <= 4'd1) state_nxt = RESP;
      end
      RESP: state_nxt = REL;
      REL:  if (!in_mst.req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and wait-counter; fields are sampled only in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      data_q   <= '0;
      cmd_q    <= CMD_RD;
      wait_cnt <= '0;
    end else begin
      if (state == IDLE && in_mst.req) begin
        addr_q <= in_mst.addr;
        data_q <= in_mst.data;
        cmd_q  <= in_mst.cmd;
      end
      if (state == CAPT)      wait_cnt <= 4'(WAIT_CYCLES);
      else if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Response path: one-cycle ack, held read/echo data, saturating errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_slv <= '0;
      err_cnt <= '0;
    end else begin
      out_slv.ack <= (state == RESP);
      if (state == RESP) begin
        if (!in_range) begin
          if (cmd_q == CMD_RD) out_slv.data <= OOR_DATA;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (cmd_q == CMD_WR) begin
          out_slv.data <= data_q;
        end else begin
          out_slv.data <= mem[idx];
        end
      end
    end
  end

  // Register file storage; only an in-range write in RESP updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == RESP && in_range && cmd_q == CMD_WR) begin
      mem[idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_bus_slave_regfile.sv
// Directed bench for bus_slave_regfile: three instances with WAIT_CYCLES
// of 0, 3 and 5 share one clock and reset.
module tb_bus_slave_regfile;
  import pkg_mst::*;
  import pkg_slv::*;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  t_mst       mst  [3];
  t_slv       slv  [3];
  logic       busy [3];
  logic [7:0] err  [3];

  int n_cmp = 0;
  int n_err = 0;

  bus_slave_regfile #(.DEPTH(8), .WAIT_CYCLES(0), .OOR_DATA(32'h0000_0000)) u_w0 (
    .clk(clk), .rst_n(rst_n), .in_mst(mst[0]), .out_slv(slv[0]),
    .busy(busy[0]), .err_cnt(err[0]));
  bus_slave_regfile #(.DEPTH(8), .WAIT_CYCLES(3), .OOR_DATA(32'hDEAD_BEEF)) u_w3 (
    .clk(clk), .rst_n(rst_n), .in_mst(mst[1]), .out_slv(slv[1]),
    .busy(busy[1]), .err_cnt(err[1]));
  bus_slave_regfile #(.DEPTH(8), .WAIT_CYCLES(5), .OOR_DATA(32'h0000_0000)) u_w5 (
    .clk(clk), .rst_n(rst_n), .in_mst(mst[2]), .out_slv(slv[2]),
    .busy(busy[2]), .err_cnt(err[2]));

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One full transfer. lat = edges after the capture edge until ack is seen
  // (-1 on timeout). hold = extra cycles req stays high after ack.
  task automatic run_txn(input int d, input logic cmd, input logic [31:0] addr,
                         input logic [31:0] data, input int hold,
                         output logic [31:0] rdata, output int lat, output int acks);
    @(negedge clk);
    mst[d].addr = addr;
    mst[d].data = data;
    mst[d].cmd  = cmd;
    mst[d].req  = 1'b1;
    lat   = -1;
    acks  = 0;
    rdata = 'x;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("busy_after_capture", 32'(busy[d]), 32'd1);
        // Fields change after capture; the transfer must not notice.
        mst[d].addr = addr ^ 32'd1;
        mst[d].data = ~data;
        mst[d].cmd  = ~cmd;
      end
      if (slv[d].ack) begin
        lat   = c - 1;
        acks++;
        rdata = slv[d].data;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (slv[d].ack) acks++;
    end
    mst[d].req = 1'b0;
    @(negedge clk);
    if (slv[d].ack) acks++;
    check("idle_after_req_low", 32'(busy[d]), 32'd0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (slv[d].ack) acks++;
    end
  endtask

  // Raise req, then drop it so the edge `drop_edge` after capture sees it low.
  task automatic run_abort(input int d, input logic [31:0] addr, input logic [31:0] data,
                           input int drop_edge, output int acks);
    @(negedge clk);
    mst[d].addr = addr;
    mst[d].data = data;
    mst[d].cmd  = WR;
    mst[d].req  = 1'b1;
    acks = 0;
    repeat (drop_edge) begin
      @(negedge clk);
      if (slv[d].ack) acks++;
    end
    mst[d].req = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(busy[d]), 32'd0);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (slv[d].ack) acks++;
    end
  endtask

  // ---------------- stimulus / scoreboard ----------------
  logic [31:0] rd;
  int          lat;
  int          acks;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) mst[d] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_ack",  32'(slv[d].ack), 32'd0);
      check("rst_data", slv[d].data, 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_err",  {24'd0, err[d]}, 32'd0);
    end
    rst_n = 1'b1;

    // WAIT_CYCLES = 3: read addr 0 after reset.
    run_txn(1, RD, 32'd0, 32'h0, 0, rd, lat, acks);
    check("w3_rd0_lat",  32'(lat), 32'd5);
    check("w3_rd0_data", rd, 32'd0);
    check("w3_rd0_acks", 32'(acks), 32'd1);

    // WAIT_CYCLES = 0: write then read addr 3.
    run_txn(0, WR, 32'd3, 32'hCAFE_0001, 0, rd, lat, acks);
    check("w0_wr3_lat",  32'(lat), 32'd2);
    check("w0_wr3_echo", rd, 32'hCAFE_0001);
    check("w0_wr3_acks", 32'(acks), 32'd1);
    run_txn(0, RD, 32'd3, 32'h0, 0, rd, lat, acks);
    check("w0_rd3_lat",  32'(lat), 32'd2);
    check("w0_rd3_data", rd, 32'hCAFE_0001);
    check("w0_rd3_acks", 32'(acks), 32'd1);
    check("w0_err0", {24'd0, err[0]}, 32'd0);

    // Top in-range address.
    run_txn(0, WR, 32'd7, 32'hFFFF_FFFF, 0, rd, lat, acks);
    run_txn(0, RD, 32'd7, 32'h0, 0, rd, lat, acks);
    check("w0_rd7_data", rd, 32'hFFFF_FFFF);

    // req held high 4 cycles past ack.
    run_txn(0, WR, 32'd5, 32'h1234_5678, 4, rd, lat, acks);
    check("hold_wr5_acks", 32'(acks), 32'd1);
    run_txn(0, RD, 32'd5, 32'h0, 0, rd, lat, acks);
    check("hold_rd5_data", rd, 32'h1234_5678);
    run_txn(0, WR, 32'd12, 32'h7777_7777, 4, rd, lat, acks);
    check("hold_oor_acks", 32'(acks), 32'd1);
    check("hold_oor_err",  {24'd0, err[0]}, 32'd1);
    run_txn(0, RD, 32'd4, 32'h0, 0, rd, lat, acks);
    check("oor_no_alias4", rd, 32'd0);

    // Out of range on DEPTH = 8: addr 8.
    run_txn(1, WR, 32'd8, 32'h5555_5555, 0, rd, lat, acks);
    check("oor_wr_acks", 32'(acks), 32'd1);
    run_txn(1, RD, 32'd8, 32'h0, 0, rd, lat, acks);
    check("oor_rd_acks", 32'(acks), 32'd1);
    check("oor_rd_data", rd, 32'hDEAD_BEEF);
    check("oor_err2",    {24'd0, err[1]}, 32'd2);
    run_txn(1, RD, 32'd0, 32'h0, 0, rd, lat, acks);
    check("oor_no_alias0", rd, 32'd0);

    // WAIT_CYCLES = 5: abort at k+3, then full transfers.
    run_abort(2, 32'd2, 32'hAAAA_AAAA, 3, acks);
    check("abort_acks", 32'(acks), 32'd0);
    run_txn(2, RD, 32'd2, 32'h0, 0, rd, lat, acks);
    check("abort_no_write", rd, 32'd0);
    check("w5_rd_lat", 32'(lat), 32'd7);
    run_txn(2, WR, 32'd2, 32'hBBBB_0002, 0, rd, lat, acks);
    run_txn(2, RD, 32'd2, 32'h0, 0, rd, lat, acks);
    check("w5_rd2_data", rd, 32'hBBBB_0002);

    // Reset during WAIT of a write to addr 1.
    @(negedge clk);
    mst[2].addr = 32'd1;
    mst[2].data = 32'h1111_1111;
    mst[2].cmd  = WR;
    mst[2].req  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ack",  32'(slv[2].ack), 32'd0);
    check("midrst_busy", 32'(busy[2]), 32'd0);
    check("midrst_err1", {24'd0, err[1]}, 32'd0);
    mst[2].req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(2, RD, 32'd1, 32'h0, 0, rd, lat, acks);
    check("midrst_rd1", rd, 32'd0);
    check("midrst_rd1_acks", 32'(acks), 32'd1);
    run_txn(0, RD, 32'd3, 32'h0, 0, rd, lat, acks);
    check("rst_clears_mem3", rd, 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_slave_regfile.md
Name: bus_slave_regfile

Overview:
Responder end of the pkg_mst/pkg_slv request/acknowledge bus. It accepts one transaction per four-phase handshake from a bus master and services it against an internal register file of DEPTH 32-bit words. Writes store data; reads return data on the response bus. It sits on the slave side of the bus, directly opposite the bus master.

Parameters:
DEPTH, 8, number of 32-bit words in the register file (power of two, 2..256)
WAIT_CYCLES, 0, extra cycles inserted between request capture and ack (0..15)
OOR_DATA, 32'h0000_0000, read data returned for out-of-range addresses

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
in_mst  input  t_mst  request bus from master: addr, data, cmd (1 = write, 0 = read), req
out_slv  output  t_slv  response bus to master: ack, data[31:0]
busy  output  1  high whenever state != IDLE
err_cnt  output  8  saturating count of out-of-range accesses

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; out_slv.ack = 0; out_slv.data = 0; busy = 0; err_cnt = 0.
  - All DEPTH words = 0; wait counter = 0.
  - Reset mid-transaction abandons it: no ack, no write.
- State machine: IDLE -> CAPT -> WAIT -> RESP -> REL -> IDLE.
- IDLE:
  - Waits for in_mst.req = 1.
  - On that edge it registers addr, data and cmd, then goes to CAPT.
- CAPT:
  - Loads the wait counter with WAIT_CYCLES.
  - Goes to WAIT if WAIT_CYCLES > 0, else to RESP.
- WAIT:
  - Decrements the counter and goes to RESP when it reaches 1.
  - If req falls while in CAPT or WAIT, the transaction is aborted: no access, no ack, return to IDLE.
- RESP (exactly one cycle): out_slv.ack = 1 for exactly this one cycle. Then go to REL.
  - Write, in range: mem[addr] <= captured data; out_slv.data <= captured data (echo).
  - Read, in range: out_slv.data <= mem[addr].
  - Out of range (addr >= DEPTH): no write; reads return OOR_DATA; err_cnt increments, saturating at 8'hFF.
- REL:
  - ack = 0; waits for req = 0, then goes to IDLE.
  - A req still high from the finished transaction is never treated as a new request.
- out_slv.data is held from RESP until the next RESP or reset. The master samples it one or more cycles after ack.
- Address decode:
  - Index = captured addr[$clog2(DEPTH)-1:0].
  - Range check compares the full addr against DEPTH.
- Latency: req sampled at edge k gives ack high after edge k+2+WAIT_CYCLES.
- Throughput: at most one transaction per 4+WAIT_CYCLES cycles.
- Bus fields other than req are read only on the IDLE capture edge. Later changes have no effect.
- A write followed by a read to the same address returns the written value; there is no bypass hazard because transactions are serialized.

Decomposition:
- Use pkg_mst::t_mst and pkg_slv::t_slv unchanged.
- Add a new package pkg_slv_st holding:
  - enum t_slv_st {IDLE, CAPT, WAIT, RESP, REL};
  - localparams CMD_WR = 1'b1 and CMD_RD = 1'b0.
- Sub-module: none required. The register file is a plain array inside the block; optionally split out as slv_regfile (sync write, registered read) if DEPTH grows.

Test Plan:
- Write 32'hCAFE_0001 to addr 3, then read addr 3, WAIT_CYCLES = 0 -> ack one cycle at k+2 each time; read returns 32'hCAFE_0001; err_cnt = 0.
- WAIT_CYCLES = 3, read addr 0 after reset -> ack first seen at k+5; data = 0; busy high from k+1 through REL.
- Master holds req high for 4 cycles after ack -> only one ack; no second access; IDLE entered the cycle after req falls.
- Write to addr 8 (DEPTH = 8), then read addr 8 -> both acked; mem unchanged; read data = OOR_DATA; err_cnt = 2.
- req dropped during WAIT (WAIT_CYCLES = 5, drop at k+3) -> no ack; write not performed; back to IDLE; next full transaction works.
- rst_n pulsed low during WAIT of a write to addr 1 -> ack = 0 immediately; mem[1] = 0; later read of addr 1 returns 0.
